// File: rtl/md_sched.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models the fixed
// multi-cycle MD latency with a down-counter and raises the E-stage stall.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  input  logic        e_uses_md,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e          state, state_d;
  logic [CW-1:0]   count, count_d;
  logic [31:0]     pend_hi, pend_hi_d;
  logic [31:0]     pend_lo, pend_lo_d;
  logic            pend_wr, pend_wr_d;
  logic [31:0]     hi_d, lo_d;

  op_e             op_w;
  logic            signed_op;
  logic            neg_a, neg_b;
  logic [63:0]     prod;
  logic [31:0]     abs_a, abs_b, div_b;
  logic [31:0]     uq, ur;
  logic [31:0]     quot, rem;

  assign op_w = op_e'(op);

  // Signed ops work on magnitudes so that 0x80000000 / -1 and the
  // remainder sign follow truncation toward zero without relying on
  // simulator-specific overflow behaviour.
  always_comb begin
    signed_op = (op_w == OP_MULT) || (op_w == OP_DIV);
    neg_a     = signed_op & a[31];
    neg_b     = signed_op & b[31];
    prod      = {{32{neg_a}}, a} * {{32{neg_b}}, b};
    abs_a     = neg_a ? (32'd0 - a) : a;
    abs_b     = neg_b ? (32'd0 - b) : b;
    div_b     = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq        = abs_a / div_b;
    ur        = abs_a % div_b;
    quot      = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    rem       = neg_a ? (32'd0 - ur) : ur;
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    count_d   = count;
    pend_hi_d = pend_hi;
    pend_lo_d = pend_lo;
    pend_wr_d = pend_wr;
    hi_d      = hi;
    lo_d      = lo;

    case (state)
      S_IDLE: begin
        if (start && !req) begin
          case (op_w)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
              count_d   = CW'(MULT_CYCLES);
              state_d   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              // Divide by zero still costs the full latency but leaves HI/LO alone.
              pend_wr_d = (b != 32'd0);
              count_d   = CW'(DIV_CYCLES);
              state_d   = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end

      S_BUSY: begin
        if (count == CW'(1)) begin
          if (pend_wr) begin
            hi_d = pend_hi;
            lo_d = pend_lo;
          end
          pend_wr_d = 1'b0;
          count_d   = '0;
          state_d   = S_IDLE;
        end else begin
          count_d = count - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_d;
      count   <= count_d;
      pend_hi <= pend_hi_d;
      pend_lo <= pend_lo_d;
      pend_wr <= pend_wr_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  assign busy  = (state == S_BUSY);
  assign stall = e_uses_md & busy;

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        e_uses_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .req       (req),
    .e_uses_md (e_uses_md),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct packed {
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          step_id  = 0;
  logic [31:0] cur_hi   = 32'd0;
  logic [31:0] cur_lo   = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("busy[%0d]", step_id),  {31'd0, busy},  {31'd0, e.busy});
      check($sformatf("stall[%0d]", step_id), {31'd0, stall}, {31'd0, e.stall});
      check($sformatf("hi[%0d]", step_id),    hi,             e.hi);
      check($sformatf("lo[%0d]", step_id),    lo,             e.lo);
      step_id++;
    end
  end

  task automatic step(input logic eb, input logic es, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.busy  = eb;
    e.stall = es;
    e.hi    = eh;
    e.lo    = el;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Issue one op at posedge+1, then expect n busy cycles followed by the new HI/LO.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic rq, input int n, input logic eu, input logic inject,
                        input logic [31:0] nh, input logic [31:0] nl);
    start     = 1'b1;
    op        = o;
    a         = av;
    b         = bv;
    req       = rq;
    e_uses_md = eu;
    step(1'b0, 1'b0, cur_hi, cur_lo);
    start = 1'b0;
    op    = 3'd0;
    req   = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (inject && i == 1) begin
        start = 1'b1;
        op    = 3'd6;
        a     = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
      end
      step(1'b1, eu, cur_hi, cur_lo);
    end
    start  = 1'b0;
    op     = 3'd0;
    a      = 32'd0;
    cur_hi = nh;
    cur_lo = nl;
    step(1'b0, 1'b0, cur_hi, cur_lo);
    e_uses_md = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    a         = 32'd0;
    b         = 32'd0;
    req       = 1'b0;
    e_uses_md = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi",   hi,            32'd0);
    check("reset_lo",   lo,            32'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // multu 0xFFFFFFFF * 2
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 5, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE);
    // mult -3 * 4 with e_uses_md held and a stray mtlo start while busy
    run_op(3'd1, 32'hFFFFFFFD, 32'd4, 1'b0, 5, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF4);
    // mult -1 * -1 (signed) vs multu of the same bits
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 1'b0, 1'b0, 32'h00000000, 32'h00000001);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    // div -7 / 2
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    // div 0x80000000 / -1
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 1'b0, 1'b0, 32'h00000000, 32'h80000000);
    // mult start suppressed by req
    run_op(3'd1, 32'd3, 32'd3, 1'b1, 0, 1'b0, 1'b0, 32'h00000000, 32'h80000000);
    // reserved op does nothing
    run_op(3'd7, 32'd3, 32'd3, 1'b0, 0, 1'b0, 1'b0, 32'h00000000, 32'h80000000);
    // mthi / mtlo
    run_op(3'd5, 32'h0000ABCD, 32'd0, 1'b0, 0, 1'b0, 1'b0, 32'h0000ABCD, 32'h80000000);
    run_op(3'd6, 32'h00001234, 32'd0, 1'b0, 0, 1'b0, 1'b0, 32'h0000ABCD, 32'h00001234);
    // divu by zero leaves HI/LO alone
    run_op(3'd5, 32'h00000011, 32'd0, 1'b0, 0, 1'b0, 1'b0, 32'h00000011, 32'h00001234);
    run_op(3'd6, 32'h00000022, 32'd0, 1'b0, 0, 1'b0, 1'b0, 32'h00000011, 32'h00000022);
    run_op(3'd4, 32'd5, 32'd0, 1'b0, 10, 1'b0, 1'b0, 32'h00000011, 32'h00000022);
    // divu 100 / 7
    run_op(3'd4, 32'd100, 32'd7, 1'b0, 10, 1'b0, 1'b0, 32'h00000002, 32'h0000000E);

    // div abandoned by an asynchronous reset in busy cycle 4
    start = 1'b1;
    op    = 3'd3;
    a     = 32'd200;
    b     = 32'd7;
    step(1'b0, 1'b0, cur_hi, cur_lo);
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) step(1'b1, 1'b0, cur_hi, cur_lo);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_hi",   hi,            32'd0);
    check("async_reset_lo",   lo,            32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    cur_hi = 32'd0;
    cur_lo = 32'd0;
    repeat (15) step(1'b0, 1'b0, 32'd0, 32'd0);

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
